// File: rtl/chunked_adder_pkg.sv
// ============================================================================
// Module  : chunked_adder_pkg
// Brief   : Shared state encoding and sizing helper for chunked_adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package chunked_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

    // Chunk counter width; a single-chunk build still needs a 1-bit counter.
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

`default_nettype wire

// File: rtl/chunked_adder_if.sv
// ============================================================================
// Module  : chunked_adder_if
// Brief   : Operand/result handshake bundle; sub exists with CHUNKED_ADDER_SUB_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface chunked_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef CHUNKED_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif

endinterface

`default_nettype wire

// File: rtl/chunked_adder_chunk_add.sv
// ============================================================================
// Module  : chunk_add
// Brief   : Combinational ripple of CHUNK full-adder cells.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunk_add #(
    parameter int CHUNK = 8
) (
    input  wire logic [CHUNK-1:0] a_i,
    input  wire logic [CHUNK-1:0] b_i,
    input  wire logic             c_i,
    output logic      [CHUNK-1:0] s_o,
    output logic                  c_o
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = c_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
        assign w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = w_c[CHUNK];

endmodule

`default_nettype wire

// File: rtl/chunked_adder.sv
// ============================================================================
// Module  : chunked_adder
// Brief   : Multi-cycle a+b+cin, CHUNK bits per clock; CHUNKED_ADDER_SUB_EN adds a-b.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    chunked_adder_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, cout_q, ovf_q;

    logic              w_accept;
    logic [WIDTH-1:0]  w_b_in;
    logic              w_c_in;
    logic [CHUNK-1:0]  w_s;
    logic              w_c;

`ifdef CHUNKED_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin is irrelevant in that mode.
    assign w_b_in = bus.sub ? ~bus.b : bus.b;
    assign w_c_in = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_b_in = bus.b;
    assign w_c_in = bus.cin;
`endif

    assign w_accept = bus.in_valid && (state_q == IDLE);

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a_i (a_q[cnt_q*CHUNK +: CHUNK]),
        .b_i (b_q[cnt_q*CHUNK +: CHUNK]),
        .c_i (carry_q),
        .s_o (w_s),
        .c_o (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)        state_d = BUSY;
            BUSY:    if (cnt_q == LAST_CNT)   state_d = DONE;
            DONE:    if (bus.out_ready)       state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (w_accept) begin
            a_q     <= bus.a;
            b_q     <= w_b_in;
            carry_q <= w_c_in;
            cnt_q   <= '0;
        end else if (state_q == BUSY) begin
            sum_q[cnt_q*CHUNK +: CHUNK] <= w_s;
            carry_q <= w_c;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
                cout_q <= w_c;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_s[CHUNK-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire
